// File: rtl/decode_ctrl_stage.sv
// Registered RISC-V decode stage.
// Each accepted instruction is decoded into a control bundle, register indices and a
// sign-extended immediate. Bundles are held in an output register (O) backed by one
// skid register (S), so upstream never sees a combinational path from out_ready.
module decode_ctrl_stage #(
    parameter int XLEN        = 64,
    parameter int ENABLE_RV64 = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [XLEN-1:0]  out_imm,
    output logic [12:0]      out_ctrl,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    // One decoded instruction as it travels through O or S.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [12:0]     ctrl;
        logic            illegal;
    } bundle_t;

    // O/S occupancy: EMPTY (O0,S0), ONE (O1,S0), FULL (O1,S1).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    // Control word layout:
    // {regWrite, aluSrc, aluOp[1:0], aluSext, memRead, memWrite, branch, jump, jumpReg, lui, auipc, excep}
    localparam logic [12:0] CTRL_OP     = 13'b1_0100_00000000;
    localparam logic [12:0] CTRL_OP32   = 13'b1_0101_00000000;
    localparam logic [12:0] CTRL_OPIMM  = 13'b1_1110_00000000;
    localparam logic [12:0] CTRL_OPIMM32= 13'b1_1111_00000000;
    localparam logic [12:0] CTRL_LOAD   = 13'b1_1000_10000000;
    localparam logic [12:0] CTRL_STORE  = 13'b0_1000_01000000;
    localparam logic [12:0] CTRL_BRANCH = 13'b0_0010_00100000;
    localparam logic [12:0] CTRL_JAL    = 13'b1_0000_00010000;
    localparam logic [12:0] CTRL_JALR   = 13'b1_1000_00001000;
    localparam logic [12:0] CTRL_LUI    = 13'b1_1000_00000100;
    localparam logic [12:0] CTRL_AUIPC  = 13'b1_1000_00000010;
    localparam logic [12:0] CTRL_SYSTEM = 13'b1_0000_00000001;

    localparam logic RV64_ON = (ENABLE_RV64 != 0);

    // Decode a raw instruction word into a bundle. Illegal encodings carry ctrl=0, imm=0.
    function automatic bundle_t decode_instr(input logic [31:0] instr, input logic [XLEN-1:0] pc);
        bundle_t         b;
        logic [12:0]     ctrl;
        logic            illegal;
        logic [31:0]     imm_i;
        logic [31:0]     imm_s;
        logic [31:0]     imm_b;
        logic [31:0]     imm_u;
        logic [31:0]     imm_j;
        logic [31:0]     imm32;
        logic [XLEN-1:0] imm_x;

        imm_i = {{20{instr[31]}}, instr[31:20]};
        imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_u = {instr[31:12], 12'd0};
        imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

        ctrl    = 13'd0;
        illegal = 1'b0;
        imm32   = 32'd0;

        case (instr[6:0])
            7'b0110011: ctrl = CTRL_OP;
            7'b0111011: begin
                ctrl    = RV64_ON ? CTRL_OP32 : 13'd0;
                illegal = ~RV64_ON;
            end
            7'b0010011: begin
                ctrl  = CTRL_OPIMM;
                imm32 = imm_i;
            end
            7'b0011011: begin
                ctrl    = RV64_ON ? CTRL_OPIMM32 : 13'd0;
                illegal = ~RV64_ON;
                imm32   = RV64_ON ? imm_i : 32'd0;
            end
            7'b0000011: begin
                ctrl  = CTRL_LOAD;
                imm32 = imm_i;
            end
            7'b0100011: begin
                ctrl  = CTRL_STORE;
                imm32 = imm_s;
            end
            7'b1100011: begin
                ctrl  = CTRL_BRANCH;
                imm32 = imm_b;
            end
            7'b1101111: begin
                ctrl  = CTRL_JAL;
                imm32 = imm_j;
            end
            7'b1100111: begin
                ctrl  = CTRL_JALR;
                imm32 = imm_i;
            end
            7'b0110111: begin
                ctrl  = CTRL_LUI;
                imm32 = imm_u;
            end
            7'b0010111: begin
                ctrl  = CTRL_AUIPC;
                imm32 = imm_u;
            end
            7'b1110011: begin
                ctrl  = CTRL_SYSTEM;
                imm32 = imm_i;
            end
            default: begin
                ctrl    = 13'd0;
                illegal = 1'b1;
            end
        endcase

        // Writes to x0 are architecturally discarded; drop regWrite so execute never sees them.
        ctrl[12] = ctrl[12] & (instr[11:7] != 5'd0);

        imm_x        = {XLEN{imm32[31]}};
        imm_x[31:0]  = imm32;

        b.pc      = pc;
        b.rs1     = instr[19:15];
        b.rs2     = instr[24:20];
        b.rd      = instr[11:7];
        b.imm     = imm_x;
        b.ctrl    = ctrl;
        b.illegal = illegal;
        return b;
    endfunction

    state_e           state_q, state_d;
    bundle_t          o_q, o_d;
    bundle_t          s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    bundle_t          dec;
    logic             accept;
    logic             hand_illegal;

    // Handshake views derived purely from registered occupancy.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);

    assign out_pc      = o_q.pc;
    assign out_rs1     = o_q.rs1;
    assign out_rs2     = o_q.rs2;
    assign out_rd      = o_q.rd;
    assign out_imm     = o_q.imm;
    assign out_ctrl    = o_q.ctrl;
    assign out_illegal = o_q.illegal;
    assign illegal_cnt = cnt_q;

    // Occupancy next-state and O/S load selection; flush wins over any accept.
    always_comb begin
        dec     = decode_instr(in_instr, in_pc);
        accept  = in_valid & in_ready;
        state_d = state_q;
        o_d     = o_q;
        s_d     = s_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        o_d     = dec;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept && out_ready) begin
                        o_d     = dec;
                        state_d = ST_ONE;
                    end else if (accept) begin
                        s_d     = dec;
                        state_d = ST_FULL;
                    end else if (out_ready) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        o_d     = s_q;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Saturating count of illegal bundles actually handed downstream.
    always_comb begin
        hand_illegal = out_valid & out_ready & o_q.illegal;
        if (hand_illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State, buffer and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            o_q     <= {$bits(bundle_t){1'b0}};
            s_q     <= {$bits(bundle_t){1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            o_q     <= o_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
